mul_cell_arbiter: RTL and testbench

MUL_CELL_ARBITER -- requirements
Module: mul_cell_arbiter

---
 rtl/mul_cell_arbiter.sv | 138 +++++++++++++
 tb/tb_mul_cell_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_cell_arbiter.sv
// Two-requester front end for a 3-partial-product multiplier cell.
// A requester is granted in IDLE, its operands are handed to the cell for one
// cycle (MUL), the cell products are folded into the low 32 bits of the
// product (SUM), and the result is held on the response channel until taken
// (RESP). Only one operation is in flight at a time.
module mul_cell_arbiter #(
  parameter int unsigned RR_EN = 1  // 1: round-robin, 0: fixed priority (req0 wins)
) (
  input  logic        clk,
  input  logic        reset_n,
  // requester 0
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  // requester 1
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  // shared response channel
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  // multiplier cell interface
  output logic [31:0] cell_src1,
  output logic [31:0] cell_src2,
  output logic        cell_en,
  input  logic [31:0] cell_p1,
  input  logic [31:0] cell_p2,
  input  logic [31:0] cell_p3
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    SUM  = 2'd2,
    RESP = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;  // requester served most recently
  logic        id_q, id_d;
  logic [31:0] src1_q, src1_d;
  logic [31:0] src2_q, src2_d;
  logic [31:0] result_q, result_d;

  logic        grant;     // 0 = req0, 1 = req1
  logic        accept;
  logic [31:0] cross_sum;

  // Arbitration: a lone requester always wins; on contention either alternate
  // away from the last winner or favour req0.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = (RR_EN != 0) ? ~last_grant_q : 1'b0;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign req0_ready = (state_q == IDLE) && req0_valid && !grant;
  assign req1_ready = (state_q == IDLE) && req1_valid &&  grant;
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  // Cross terms share the same 2^16 weight, so they are added before shifting;
  // every sum wraps at 32 bits, leaving the low word of the full product.
  assign cross_sum = cell_p2 + cell_p3;

  // Next-state and datapath update decisions.
  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    src1_d       = src1_q;
    src2_d       = src2_q;
    result_d     = result_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d      = MUL;
          id_d         = grant;
          last_grant_d = grant;
          src1_d       = grant ? req1_a : req0_a;
          src2_d       = grant ? req1_b : req0_b;
        end
      end
      MUL: begin
        state_d = SUM;
      end
      SUM: begin
        result_d = cell_p1 + (cross_sum << 16);
        state_d  = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any in-flight operation.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;  // req0 wins the first contention after reset
      id_q         <= 1'b0;
      src1_q       <= '0;
      src2_q       <= '0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      src1_q       <= src1_d;
      src2_q       <= src2_d;
      result_q     <= result_d;
    end
  end

  assign cell_en    = (state_q == MUL);
  assign cell_src1  = src1_q;
  assign cell_src2  = src2_q;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = id_q;
  assign rsp_result = result_q;

endmodule

// File: tb/tb_mul_cell_arbiter.sv
// Bench for mul_cell_arbiter: a round-robin and a fixed-priority instance
// share the request stimulus; each has its own 1-cycle multiplier cell model.
module tb_mul_cell_arbiter;

  localparam int N_RAND = 4000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0_valid, req1_valid, rsp_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;

  logic        rr_req0_ready, rr_req1_ready, rr_rsp_valid, rr_rsp_id, rr_cell_en;
  logic [31:0] rr_rsp_result, rr_cell_src1, rr_cell_src2, rr_p1, rr_p2, rr_p3;
  logic        fp_req0_ready, fp_req1_ready, fp_rsp_valid, fp_rsp_id, fp_cell_en;
  logic [31:0] fp_rsp_result, fp_cell_src1, fp_cell_src2, fp_p1, fp_p2, fp_p3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mul_cell_arbiter #(.RR_EN(1)) u_rr (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(rr_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(rr_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rr_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rr_rsp_id), .rsp_result(rr_rsp_result),
    .cell_src1(rr_cell_src1), .cell_src2(rr_cell_src2), .cell_en(rr_cell_en),
    .cell_p1(rr_p1), .cell_p2(rr_p2), .cell_p3(rr_p3)
  );

  mul_cell_arbiter #(.RR_EN(0)) u_fp (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(fp_rsp_id), .rsp_result(fp_rsp_result),
    .cell_src1(fp_cell_src1), .cell_src2(fp_cell_src2), .cell_en(fp_cell_en),
    .cell_p1(fp_p1), .cell_p2(fp_p2), .cell_p3(fp_p3)
  );

  function automatic logic [31:0] mul16(input logic [15:0] x, input logic [15:0] y);
    return {16'b0, x} * {16'b0, y};
  endfunction

  // Multiplier cell models: products registered one cycle after cell_en.
  always @(posedge clk) begin
    if (rr_cell_en) begin
      rr_p1 <= mul16(rr_cell_src1[15:0],  rr_cell_src2[15:0]);
      rr_p2 <= mul16(rr_cell_src1[15:0],  rr_cell_src2[31:16]);
      rr_p3 <= mul16(rr_cell_src1[31:16], rr_cell_src2[15:0]);
    end
    if (fp_cell_en) begin
      fp_p1 <= mul16(fp_cell_src1[15:0],  fp_cell_src2[15:0]);
      fp_p2 <= mul16(fp_cell_src1[15:0],  fp_cell_src2[31:16]);
      fp_p3 <= mul16(fp_cell_src1[31:16], fp_cell_src2[15:0]);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic id, input logic v, input logic [31:0] a, input logic [31:0] b);
    if (id == 1'b0) begin req0_valid = v; req0_a = a; req0_b = b; end
    else            begin req1_valid = v; req1_a = a; req1_b = b; end
  endtask

  // Raise valid at a negedge, wait (bounded) for ready, pass the acceptance
  // edge and drop valid at the following negedge (block is then in MUL).
  task automatic issue(input logic id, input logic [31:0] a, input logic [31:0] b);
    logic got;
    got = 1'b0;
    set_req(id, 1'b1, a, b);
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (id ? rr_req1_ready : rr_req0_ready) got = 1'b1;
      else @(negedge clk);
    end
    check("issue_ready", got, 1'b1);
    @(posedge clk);
    @(negedge clk);
    if (id == 1'b0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  // One operation with rsp_ready high, checking each stage of the pipeline.
  task automatic run_op(input string tag, input logic id, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    rsp_ready = 1'b1;
    issue(id, a, b);
    check({tag, "_mul_en"},   rr_cell_en, 1'b1);
    check({tag, "_src1"},     rr_cell_src1, a);
    check({tag, "_src2"},     rr_cell_src2, b);
    check({tag, "_mul_vld"},  rr_rsp_valid, 1'b0);
    @(negedge clk);
    check({tag, "_sum_en"},   rr_cell_en, 1'b0);
    check({tag, "_sum_vld"},  rr_rsp_valid, 1'b0);
    @(negedge clk);
    check({tag, "_rsp_vld"},  rr_rsp_valid, 1'b1);
    check({tag, "_rsp_id"},   rr_rsp_id, id);
    check({tag, "_result"},   rr_rsp_result, exp);
    check({tag, "_src_hold"}, rr_cell_src1, a);
    @(negedge clk);
    check({tag, "_one_cycle"}, rr_rsp_valid, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h0001_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        rr_ids [4];
    logic        fp_ids [4];
    int          rr_cnt, fp_cnt;
    logic [32:0] exp_q [$];
    logic [32:0] e;
    logic [31:0] prod;
    logic        hs, acc0, acc1;
    int          accepted, responded;

    reset_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;

    // Reset state
    #12;
    check("rst_rsp_valid",  rr_rsp_valid, 1'b0);
    check("rst_rsp_id",     rr_rsp_id, 1'b0);
    check("rst_rsp_result", rr_rsp_result, 32'h0);
    check("rst_cell_en",    rr_cell_en, 1'b0);
    check("rst_src1",       rr_cell_src1, 32'h0);
    check("rst_src2",       rr_cell_src2, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Basic operations, including wrap of the low product word
    run_op("op_basic", 1'b0, 32'h0001_2345, 32'h0000_0010, 32'h0012_3450);
    run_op("op_ones",  1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    run_op("op_wrap",  1'b1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000);

    // Continuous contention: round-robin alternates, fixed priority keeps req0
    do_reset();
    rsp_ready = 1'b1;
    set_req(1'b0, 1'b1, 32'd3, 32'd5);
    set_req(1'b1, 1'b1, 32'd7, 32'd9);
    #1;
    check("first_contention_r0", rr_req0_ready, 1'b1);
    check("first_contention_r1", rr_req1_ready, 1'b0);
    rr_cnt = 0; fp_cnt = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (rr_rsp_valid && rr_cnt < 4) begin
        rr_ids[rr_cnt] = rr_rsp_id;
        check("rr_seq_result", rr_rsp_result, rr_rsp_id ? 32'd63 : 32'd15);
        rr_cnt++;
      end
      if (fp_rsp_valid && fp_cnt < 4) begin
        fp_ids[fp_cnt] = fp_rsp_id;
        check("fp_seq_result", fp_rsp_result, fp_rsp_id ? 32'd63 : 32'd15);
        fp_cnt++;
      end
      if (rr_cnt == 4 && fp_cnt == 4) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        break;
      end
      @(negedge clk);
    end
    check("rr_seq_count", rr_cnt, 4);
    check("fp_seq_count", fp_cnt, 4);
    for (int k = 0; k < 4 && k < rr_cnt; k++) check($sformatf("rr_id%0d", k), rr_ids[k], k[0]);
    for (int k = 0; k < 4 && k < fp_cnt; k++) check($sformatf("fp_id%0d", k), fp_ids[k], 1'b0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);

    // Back-pressure: response held stable, nothing else granted
    rsp_ready = 1'b0;
    issue(1'b0, 32'h0000_1000, 32'h0000_0003);
    set_req(1'b1, 1'b1, 32'h0000_0020, 32'h0000_0004);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid",  rr_rsp_valid, 1'b1);
      check("stall_result", rr_rsp_result, 32'h0000_3000);
      check("stall_id",     rr_rsp_id, 1'b0);
      check("stall_ready",  {rr_req0_ready, rr_req1_ready}, 2'b00);
      check("stall_cell",   rr_cell_en, 1'b0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("stall_release_ready", rr_req1_ready, 1'b1);
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("after_stall_valid",  rr_rsp_valid, 1'b1);
    check("after_stall_id",     rr_rsp_id, 1'b1);
    check("after_stall_result", rr_rsp_result, 32'h0000_0080);
    @(negedge clk);

    // Reset in SUM drops the operation; the held request is served again
    rsp_ready = 1'b1;
    set_req(1'b0, 1'b1, 32'd6, 32'd7);
    #1;
    check("rst_mid_ready", rr_req0_ready, 1'b1);
    @(negedge clk);
    check("rst_mid_mul", rr_cell_en, 1'b1);
    @(negedge clk);
    check("rst_mid_sum_vld", rr_rsp_valid, 1'b0);
    reset_n = 1'b0;
    #1;
    check("rst_mid_async_vld",    rr_rsp_valid, 1'b0);
    check("rst_mid_async_result", rr_rsp_result, 32'h0);
    check("rst_mid_async_src1",   rr_cell_src1, 32'h0);
    @(negedge clk);
    check("rst_mid_held_vld", rr_rsp_valid, 1'b0);
    reset_n = 1'b1;
    #1;
    check("rst_mid_reaccept", rr_req0_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    check("rst_mid_no_rsp", rr_rsp_valid, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_rsp_vld",    rr_rsp_valid, 1'b1);
    check("rst_mid_rsp_id",     rr_rsp_id, 1'b0);
    check("rst_mid_rsp_result", rr_rsp_result, 32'd42);
    @(negedge clk);

    // Random operands, random valid and rsp_ready, against a*b mod 2^32
    accepted = 0;
    responded = 0;
    req0_a = rand_operand(); req0_b = rand_operand();
    req1_a = rand_operand(); req1_b = rand_operand();
    for (int cyc = 0; cyc < 60000 && responded < N_RAND; cyc++) begin
      @(negedge clk);
      hs   = rr_rsp_valid && rsp_ready;
      acc0 = req0_valid && rr_req0_ready;
      acc1 = req1_valid && rr_req1_ready;
      if (rr_req0_ready && rr_req1_ready) check("rand_one_ready", 1'b1, 1'b0);
      if (hs) begin
        if (exp_q.size() == 0) begin
          check("rand_extra_rsp", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("rand_id",     rr_rsp_id, e[32]);
          check("rand_result", rr_rsp_result, e[31:0]);
        end
        responded++;
      end
      if (acc0) begin prod = req0_a * req0_b; exp_q.push_back({1'b0, prod}); accepted++; end
      if (acc1) begin prod = req1_a * req1_b; exp_q.push_back({1'b1, prod}); accepted++; end
      @(posedge clk);
      #1;
      if (accepted >= N_RAND) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end else begin
        if (acc0) begin
          req0_a = rand_operand(); req0_b = rand_operand();
          req0_valid = ($urandom_range(0, 3) != 0);
        end else if (!req0_valid) begin
          req0_valid = ($urandom_range(0, 1) != 0);
        end
        if (acc1) begin
          req1_a = rand_operand(); req1_b = rand_operand();
          req1_valid = ($urandom_range(0, 3) != 0);
        end else if (!req1_valid) begin
          req1_valid = ($urandom_range(0, 1) != 0);
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    check("rand_responses", responded, N_RAND);
    check("rand_pending",   exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
